// File: rtl/rope_array_controller_if.sv
// Bus bundle between game logic / VGA mux (master) and the rope engine (slave).
interface rope_array_controller_if #(
  parameter int ROPES = 6
);
  logic                   startOfFrame;
  logic [10:0]            pixelX;
  logic [10:0]            pixelY;
  logic                   freeze;
  logic [ROPES-1:0]       dirToggle;
  logic [ROPES-1:0]       electroTrig;
  logic [ROPES-1:0][3:0]  speedMag;
  logic                   monkeyDR;
  logic [ROPES-1:0]       ropeDR;
  logic                   anyRopeDR;
  logic [7:0]             ropeRGB;
  logic [ROPES-1:0][1:0]  electroStatus;
  logic [ROPES-1:0][10:0] ropeX;
  logic                   shockHit;
  logic [3:0]             shockRope;

  modport master (
    output startOfFrame, pixelX, pixelY, freeze, dirToggle, electroTrig, speedMag, monkeyDR,
    input  ropeDR, anyRopeDR, ropeRGB, electroStatus, ropeX, shockHit, shockRope
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, freeze, dirToggle, electroTrig, speedMag, monkeyDR,
    output ropeDR, anyRopeDR, ropeRGB, electroStatus, ropeX, shockHit, shockRope
  );
endinterface

// File: rtl/rope_array_controller.sv
// N-rope engine: bounded self-reversing swing, per-rope electrification FSM,
// merged rope layer for the VGA mux and frame-sticky monkey shock detection.
module rope_array_controller #(
  parameter int         ROPES       = 6,
  parameter int         LEFT_ROPES  = 3,
  parameter int         LEFT_X0     = 100,
  parameter int         RIGHT_X0    = 400,
  parameter int         SPACING     = 32,
  parameter int         SWING       = 16,
  parameter int         TOP_Y       = 80,
  parameter int         ROPE_LEN    = 240,
  parameter int         ROPE_W      = 4,
  parameter int         WARN_FRAMES = 60,
  parameter int         LIVE_FRAMES = 120,
  parameter int         COOL_FRAMES = 30,
  parameter logic [7:0] RGB_IDLE    = 8'hB4,
  parameter logic [7:0] RGB_WARN    = 8'hFC,
  parameter logic [7:0] RGB_LIVE    = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  rope_array_controller_if.slave bus
);

  typedef enum logic [1:0] {
    E_OFF  = 2'd0,
    E_WARN = 2'd1,
    E_LIVE = 2'd2,
    E_COOL = 2'd3
  } estate_t;

  localparam logic [7:0]         WARN_LAST = 8'(WARN_FRAMES - 1);
  localparam logic [7:0]         LIVE_LAST = 8'(LIVE_FRAMES - 1);
  localparam logic [7:0]         COOL_LAST = 8'(COOL_FRAMES - 1);
  localparam logic signed [11:0] W_M1      = 12'(ROPE_W - 1);
  localparam logic [10:0]        Y_LO      = 11'(TOP_Y);
  localparam logic [10:0]        Y_HI      = 11'(TOP_Y + ROPE_LEN - 1);

  function automatic int home_x(input int i);
    return (i < LEFT_ROPES) ? LEFT_X0 + i * SPACING
                            : RIGHT_X0 + (i - LEFT_ROPES) * SPACING;
  endfunction

  function automatic logic signed [11:0] sat_x(input logic signed [11:0] v,
                                               input logic signed [11:0] lo,
                                               input logic signed [11:0] hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // WARN blinks on bit 3 of the in-state frame counter.
  function automatic logic [7:0] rope_colour(input estate_t st, input logic [7:0] cnt);
    case (st)
      E_WARN:  return cnt[3] ? RGB_WARN : RGB_IDLE;
      E_LIVE:  return RGB_LIVE;
      default: return RGB_IDLE;
    endcase
  endfunction

  logic                     adv;
  logic signed [11:0]       x_lo     [ROPES];
  logic signed [11:0]       x_hi     [ROPES];
  logic signed [11:0]       x_q      [ROPES];
  logic signed [11:0]       cand     [ROPES];
  logic signed [11:0]       x_nxt    [ROPES];
  logic [ROPES-1:0]         left_q;
  logic [ROPES-1:0]         left_nxt;
  logic [ROPES-1:0]         dir_eff;
  logic [ROPES-1:0]         dpend_q;
  logic [ROPES-1:0]         epend_q;
  logic [ROPES-1:0]         trig_eff;
  estate_t                  st_q     [ROPES];
  estate_t                  st_nxt   [ROPES];
  logic [7:0]               cnt_q    [ROPES];
  logic [7:0]               cnt_nxt  [ROPES];
  logic [7:0]               colour   [ROPES];
  logic [ROPES-1:0]         is_live;

  logic signed [11:0]       px;
  logic                     y_in;
  logic [ROPES-1:0]         hit;
  logic [ROPES-1:0]         live_hit;
  logic [7:0]               rgb_sel;

  logic [ROPES-1:0]         hit_p1;
  logic [ROPES-1:0]         live_p1;
  logic [7:0]               rgb_p1;
  logic                     mon_p1;
  logic [3:0]               low_idx;
  logic                     shock_p2;
  logic [3:0]               rope_p2;

  assign adv      = bus.startOfFrame & ~bus.freeze;
  assign trig_eff = epend_q | bus.electroTrig;

  for (genvar g = 0; g < ROPES; g++) begin : g_rope
    assign x_lo[g]              = 12'(home_x(g) - SWING);
    assign x_hi[g]              = 12'(home_x(g) + SWING);
    assign bus.ropeX[g]         = x_q[g][10:0];
    assign bus.electroStatus[g] = st_q[g];
  end

  // Swing step; a bound reversal overrides any toggle applied this frame.
  always_comb begin
    for (int i = 0; i < ROPES; i++) begin
      dir_eff[i]  = left_q[i] ^ (dpend_q[i] | bus.dirToggle[i]);
      cand[i]     = dir_eff[i] ? x_q[i] - $signed({8'd0, bus.speedMag[i]})
                               : x_q[i] + $signed({8'd0, bus.speedMag[i]});
      x_nxt[i]    = sat_x(cand[i], x_lo[i], x_hi[i]);
      left_nxt[i] = (cand[i] > x_hi[i]) ? 1'b1 :
                    (cand[i] < x_lo[i]) ? 1'b0 : dir_eff[i];
    end
  end

  // Frame stage: position, direction and pending requests
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROPES; i++) x_q[i] <= 12'(home_x(i));
      left_q  <= '0;
      dpend_q <= '0;
      epend_q <= '0;
    end else begin
      dpend_q <= adv ? '0 : (dpend_q | bus.dirToggle);
      epend_q <= adv ? '0 : (epend_q | bus.electroTrig);
      if (adv) begin
        for (int i = 0; i < ROPES; i++) x_q[i] <= x_nxt[i];
        left_q <= left_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROPES; i++) begin
        st_q[i]  <= E_OFF;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ROPES; i++) begin
        st_q[i]  <= st_nxt[i];
        cnt_q[i] <= cnt_nxt[i];
      end
    end
  end

  // Triggers arriving outside OFF are dropped when the pending bit is consumed.
  always_comb begin
    for (int i = 0; i < ROPES; i++) begin
      st_nxt[i]  = st_q[i];
      cnt_nxt[i] = cnt_q[i];
      if (adv) begin
        case (st_q[i])
          E_OFF: begin
            if (trig_eff[i]) begin
              st_nxt[i]  = E_WARN;
              cnt_nxt[i] = '0;
            end
          end
          E_WARN: begin
            if (cnt_q[i] == WARN_LAST) begin
              st_nxt[i]  = E_LIVE;
              cnt_nxt[i] = '0;
            end else begin
              cnt_nxt[i] = cnt_q[i] + 8'd1;
            end
          end
          E_LIVE: begin
            if (cnt_q[i] == LIVE_LAST) begin
              st_nxt[i]  = E_COOL;
              cnt_nxt[i] = '0;
            end else begin
              cnt_nxt[i] = cnt_q[i] + 8'd1;
            end
          end
          default: begin
            if (cnt_q[i] == COOL_LAST) begin
              st_nxt[i]  = E_OFF;
              cnt_nxt[i] = '0;
            end else begin
              cnt_nxt[i] = cnt_q[i] + 8'd1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ROPES; i++) begin
      colour[i]  = rope_colour(st_q[i], cnt_q[i]);
      is_live[i] = (st_q[i] == E_LIVE);
    end
  end

  assign px   = $signed({1'b0, bus.pixelX});
  assign y_in = (bus.pixelY >= Y_LO) && (bus.pixelY <= Y_HI);

  // Lowest index wins the merged colour.
  always_comb begin
    rgb_sel = '0;
    for (int i = 0; i < ROPES; i++) begin
      hit[i]      = y_in && (px >= x_q[i]) && (px <= x_q[i] + W_M1);
      live_hit[i] = hit[i] && is_live[i];
    end
    for (int i = ROPES - 1; i >= 0; i--) begin
      if (hit[i]) rgb_sel = colour[i];
    end
  end

  // Pixel stage p1: registered drawing requests and shock candidates
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_p1  <= '0;
      live_p1 <= '0;
      rgb_p1  <= '0;
      mon_p1  <= 1'b0;
    end else begin
      hit_p1  <= hit;
      live_p1 <= live_hit;
      rgb_p1  <= rgb_sel;
      mon_p1  <= bus.monkeyDR;
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = ROPES - 1; i >= 0; i--) begin
      if (live_p1[i]) low_idx = 4'(i);
    end
  end

  // Shock stage p2: first overlap of the frame is kept; frame start clears
  always_ff @(posedge clk) begin
    if (reset || bus.startOfFrame) begin
      shock_p2 <= 1'b0;
      rope_p2  <= '0;
    end else if (mon_p1 && (|live_p1) && !shock_p2) begin
      shock_p2 <= 1'b1;
      rope_p2  <= low_idx;
    end
  end

  assign bus.ropeDR    = hit_p1;
  assign bus.anyRopeDR = |hit_p1;
  assign bus.ropeRGB   = rgb_p1;
  assign bus.shockHit  = shock_p2;
  assign bus.shockRope = rope_p2;

endmodule

// File: tb/tb_rope_array_controller.sv
// Directed and randomised bench for rope_array_controller with a frame-level
// reference model (positions as integers, electrification as age since trigger).
module tb_rope_array_controller;
  localparam int R  = 6;
  localparam int WF = 60;
  localparam int LF = 120;
  localparam int CF = 30;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rope_array_controller_if #(.ROPES(R)) bus ();
  rope_array_controller #(.ROPES(R)) dut (.clk(clk), .reset(reset), .bus(bus));

  int         n_checks = 0;
  int         n_errors = 0;

  int         m_x   [R];
  bit         m_left[R];
  bit         m_dp  [R];
  bit         m_ep  [R];
  int         m_age [R];
  bit [R-1:0] m_live_p;
  bit         m_mon_p;
  bit [R-1:0] e_dr;
  bit [7:0]   e_rgb;
  bit         e_sh;
  bit [3:0]   e_sr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int home(input int i);
    return (i < 3) ? 100 + 32 * i : 400 + 32 * (i - 3);
  endfunction

  function automatic int st_of(input int a);
    if (a < 0)       return 0;
    if (a < WF)      return 1;
    if (a < WF + LF) return 2;
    return 3;
  endfunction

  function automatic int cnt_of(input int a);
    if (a < 0)       return 0;
    if (a < WF)      return a;
    if (a < WF + LF) return a - WF;
    return a - WF - LF;
  endfunction

  function automatic bit [7:0] colour_of(input int i);
    case (st_of(m_age[i]))
      1:       return ((cnt_of(m_age[i]) & 8) != 0) ? 8'hFC : 8'hB4;
      2:       return 8'hFF;
      default: return 8'hB4;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < R; i++) begin
      m_x[i] = home(i); m_left[i] = 0; m_dp[i] = 0; m_ep[i] = 0; m_age[i] = -1;
    end
    m_live_p = '0; m_mon_p = 0; e_dr = '0; e_rgb = '0; e_sh = 0; e_sr = '0;
  endtask

  // Applies one clock edge worth of inputs to the reference model.
  task automatic model_edge();
    bit [R-1:0] hits, lives;
    bit [7:0]   rgb;
    int         px, py, s, nx, lo, hi;
    bit         d;
    if (reset) begin
      model_reset();
      return;
    end
    px = int'(bus.pixelX); py = int'(bus.pixelY);
    hits = '0; lives = '0; rgb = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (py >= 80 && py < 320 && px >= m_x[i] && px < m_x[i] + 4) begin
        hits[i] = 1;
        rgb = colour_of(i);
        if (st_of(m_age[i]) == 2) lives[i] = 1;
      end
    end
    if (bus.startOfFrame) begin
      e_sh = 0; e_sr = '0;
    end else if (m_mon_p && m_live_p != 0 && !e_sh) begin
      e_sh = 1;
      for (int i = R - 1; i >= 0; i--) if (m_live_p[i]) e_sr = 4'(i);
    end
    e_dr = hits; e_rgb = rgb; m_live_p = lives; m_mon_p = bus.monkeyDR;
    for (int i = 0; i < R; i++) begin
      m_dp[i] |= bus.dirToggle[i];
      m_ep[i] |= bus.electroTrig[i];
    end
    if (bus.startOfFrame && !bus.freeze) begin
      for (int i = 0; i < R; i++) begin
        s  = int'(bus.speedMag[i]);
        d  = m_left[i] ^ m_dp[i];
        nx = d ? m_x[i] - s : m_x[i] + s;
        lo = home(i) - 16; hi = home(i) + 16;
        if (nx > hi)      begin m_x[i] = hi; m_left[i] = 1; end
        else if (nx < lo) begin m_x[i] = lo; m_left[i] = 0; end
        else              begin m_x[i] = nx; m_left[i] = d; end
        if (m_age[i] >= 0) begin
          m_age[i]++;
          if (m_age[i] >= WF + LF + CF) m_age[i] = -1;
        end else if (m_ep[i]) begin
          m_age[i] = 0;
        end
        m_dp[i] = 0; m_ep[i] = 0;
      end
    end
  endtask

  task automatic compare();
    chk("ropeDR", bus.ropeDR, e_dr);
    chk("anyRopeDR", bus.anyRopeDR, |e_dr);
    chk("ropeRGB", bus.ropeRGB, e_rgb);
    chk("shockHit", bus.shockHit, e_sh);
    chk("shockRope", bus.shockRope, e_sr);
    for (int i = 0; i < R; i++) begin
      chk($sformatf("ropeX[%0d]", i), bus.ropeX[i], m_x[i]);
      chk($sformatf("electroStatus[%0d]", i), bus.electroStatus[i], st_of(m_age[i]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    bus.startOfFrame = 1'b0;
    bus.dirToggle    = '0;
    bus.electroTrig  = '0;
  endtask

  task automatic frame(input int len);
    bus.startOfFrame = 1'b1;
    cyc();
    repeat (len - 1) cyc();
  endtask

  task automatic do_reset();
    bus.startOfFrame = 0; bus.freeze = 0; bus.dirToggle = '0; bus.electroTrig = '0;
    bus.speedMag = '0; bus.monkeyDR = 0; bus.pixelX = '0; bus.pixelY = '0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int seq[10] = '{104, 108, 112, 116, 116, 112, 108, 104, 100, 96};
    int gap;
    int p;
    int r;

    do_reset();
    cyc();
    chk("rst_ropeX0", bus.ropeX[0], 100);
    chk("rst_ropeX3", bus.ropeX[3], 400);
    chk("rst_status", bus.electroStatus, 0);
    chk("rst_shock", bus.shockHit, 0);

    // Bounded swing with bounce at MAX.
    bus.speedMag[0] = 4'd4;
    for (int f = 0; f < 10; f++) begin
      frame(4);
      chk("swing_x0", bus.ropeX[0], seq[f]);
    end

    // Mid-frame direction toggle.
    do_reset();
    bus.speedMag[2] = 4'd2;
    cyc();
    bus.dirToggle[2] = 1'b1;
    cyc();
    frame(4);
    chk("toggle_x2", bus.ropeX[2], 162);

    // Full electrification cycle; retrigger during LIVE is ignored.
    do_reset();
    bus.electroTrig[1] = 1'b1;
    cyc();
    for (int k = 1; k <= 212; k++) begin
      if (k == 100) bus.electroTrig[1] = 1'b1;
      frame(2);
      if (k == 1)   chk("el_warn_first", bus.electroStatus[1], 1);
      if (k == 60)  chk("el_warn_last", bus.electroStatus[1], 1);
      if (k == 61)  chk("el_live_first", bus.electroStatus[1], 2);
      if (k == 180) chk("el_live_last", bus.electroStatus[1], 2);
      if (k == 181) chk("el_cool_first", bus.electroStatus[1], 3);
      if (k == 210) chk("el_cool_last", bus.electroStatus[1], 3);
      if (k == 211) chk("el_off", bus.electroStatus[1], 0);
      if (k == 212) chk("el_stays_off", bus.electroStatus[1], 0);
    end

    // Pixel hit window.
    do_reset();
    bus.pixelX = 11'd102; bus.pixelY = 11'd100;
    cyc();
    chk("pix_hit_dr0", bus.ropeDR[0], 1);
    chk("pix_hit_rgb", bus.ropeRGB, 8'hB4);
    bus.pixelX = 11'd104; bus.pixelY = 11'd100;
    cyc();
    chk("pix_right_edge", bus.ropeDR[0], 0);
    bus.pixelX = 11'd102; bus.pixelY = 11'd79;
    cyc();
    chk("pix_above_top", bus.ropeDR[0], 0);
    chk("pix_above_rgb", bus.ropeRGB, 0);

    // Shock detection on a LIVE rope.
    do_reset();
    bus.electroTrig[0] = 1'b1;
    for (int k = 0; k < 61; k++) frame(2);
    chk("shk_live", bus.electroStatus[0], 2);
    bus.monkeyDR = 1'b1; bus.pixelX = 11'd101; bus.pixelY = 11'd150;
    cyc();
    bus.monkeyDR = 1'b0; bus.pixelX = 11'd0; bus.pixelY = 11'd0;
    chk("shk_not_yet", bus.shockHit, 0);
    cyc();
    chk("shk_hit", bus.shockHit, 1);
    chk("shk_rope", bus.shockRope, 0);
    cyc();
    chk("shk_sticky", bus.shockHit, 1);
    frame(2);
    chk("shk_cleared", bus.shockHit, 0);

    // Freeze during WARN; pending toggle survives the freeze.
    do_reset();
    bus.speedMag[0] = 4'd3;
    bus.electroTrig[0] = 1'b1;
    for (int k = 0; k < 4; k++) frame(3);
    chk("frz_pre_x0", bus.ropeX[0], 112);
    bus.freeze = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) bus.dirToggle[0] = 1'b1;
      frame(3);
    end
    chk("frz_hold_x0", bus.ropeX[0], 112);
    chk("frz_hold_st", bus.electroStatus[0], 1);
    bus.freeze = 1'b0;
    frame(3);
    chk("frz_resume_x0", bus.ropeX[0], 109);
    for (int k = 2; k <= 57; k++) begin
      frame(2);
      if (k == 56) chk("frz_warn_end", bus.electroStatus[0], 1);
      if (k == 57) chk("frz_live", bus.electroStatus[0], 2);
    end

    // Randomised traffic.
    do_reset();
    gap = 0;
    for (int c = 0; c < 3000; c++) begin
      if (gap == 0) begin
        bus.startOfFrame = 1'b1;
        gap = int'($urandom_range(3, 10));
        bus.freeze = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0)
          for (int i = 0; i < R; i++) bus.speedMag[i] = 4'($urandom_range(0, 15));
      end else begin
        gap--;
      end
      for (int i = 0; i < R; i++) begin
        bus.dirToggle[i]   = ($urandom_range(0, 15) == 0);
        bus.electroTrig[i] = ($urandom_range(0, 63) == 0);
      end
      r = int'($urandom_range(0, R - 1));
      p = m_x[r] + int'($urandom_range(0, 7)) - 2;
      if (p < 0) p = 0;
      bus.pixelX   = 11'(p);
      bus.pixelY   = 11'($urandom_range(60, 340));
      bus.monkeyDR = ($urandom_range(0, 2) == 0);
      reset        = ($urandom_range(0, 499) == 0);
      cyc();
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rope_array_controller.md
# rope_array_controller

Parametrised N-rope engine that owns the position, swing direction and electrification state of every rope and renders them as a single merged layer. Sits between the game-logic layer (direction toggles, electrify triggers, per-rope speed) and the VGA object mux. Beyond a plain per-rope display it adds bounded self-reversing swing, a per-rope electrification FSM and frame-sticky shock detection against the monkey.

## Interface
- ROPES, 6, total rope count (1..16)
- LEFT_ROPES, 3, ropes 0..LEFT_ROPES-1 are left group; rest right group
- LEFT_X0, 100, home X of rope 0; RIGHT_X0, 400, home X of rope LEFT_ROPES
- SPACING, 32, home X step between adjacent ropes in a group
- SWING, 16, max excursion from home X (pixels, each side)
- TOP_Y, 80, ROPE_LEN, 240, ROPE_W, 4, rope rectangle geometry
- WARN_FRAMES, 60, LIVE_FRAMES, 120, COOL_FRAMES, 30, FSM durations in frames (1..255)
- RGB_IDLE, 8'hB4, RGB_WARN, 8'hFC, RGB_LIVE, 8'hFF, 8-bit colours

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- pixelX, pixelY  in  11 each  current VGA pixel
- freeze  in  1  level; holds motion and FSM timers
- dirToggle  in  ROPES  per-rope one-cycle request to reverse
- electroTrig  in  ROPES  per-rope one-cycle request to electrify
- speedMag  in  ROPES x 4  per-rope pixels/frame
- monkeyDR  in  1  monkey drawing request, aligned with pixelX/Y
- ropeDR  out  ROPES  per-rope drawing request (registered)
- anyRopeDR  out  1  OR of ropeDR
- ropeRGB  out  8  colour of lowest-index active rope
- electroStatus  out  ROPES x 2  0 OFF, 1 WARN, 2 LIVE, 3 COOL
- ropeX  out  ROPES x 11  current left edge per rope
- shockHit  out  1  frame-sticky monkey/live-rope overlap
- shockRope  out  4  index of lowest live rope overlapped this frame

## Operation
- Home X: i<LEFT_ROPES → LEFT_X0+i·SPACING; else RIGHT_X0+(i−LEFT_ROPES)·SPACING. Bounds MIN=home−SWING, MAX=home+SWING.
- dirToggle pulses latch into per-rope pending bit; pending consumed at next startOfFrame.
- On startOfFrame, freeze=0, per rope in order: dir ^= pending; next = x ± speedMag (12-bit signed intermediate); next>MAX → x=MAX, dir=left; next<MIN → x=MIN, dir=right; else x=next. Bound reversal overrides toggle in same frame. speedMag=0 → no move, toggle still applied.
- Electro FSM per rope, advances only on startOfFrame with freeze=0: OFF --electroTrig(latched)--> WARN; WARN after WARN_FRAMES → LIVE; LIVE after LIVE_FRAMES → COOL; COOL after COOL_FRAMES → OFF. Trigger while not OFF is discarded. 8-bit frame counter reloads to 0 on each state entry; transition when counter reaches duration−1.
- Pixel hit: pixelX in [x, x+ROPE_W−1] and pixelY in [TOP_Y, TOP_Y+ROPE_LEN−1].
- Colour: OFF/COOL → RGB_IDLE; WARN → RGB_WARN when counter bit 3 =1 else RGB_IDLE (blink every 8 frames); LIVE → RGB_LIVE.
- ropeRGB = colour of lowest-index rope with ropeDR; 8'h00 when none.
- Shock: monkeyDR registered alongside hit; overlap with any LIVE rope sets shockHit and captures shockRope (lowest index) if shockHit was 0. Both cleared on startOfFrame (clear wins over same-cycle set).

## Timing
- Reset: x=home, dir=right, pending=0, FSM=OFF, counters=0, ropeDR=0, anyRopeDR=0, ropeRGB=0, shockHit=0, shockRope=0.
- ropeDR/anyRopeDR/ropeRGB: 1 clk after pixelX/Y.
- ropeX, electroStatus: update 1 clk after startOfFrame.
- shockHit: asserted 2 clk after coincident monkeyDR/pixel.
- dirToggle/electroTrig same cycle as startOfFrame: applied this frame.
- Reset mid-frame: all state to reset values next cycle; pending requests dropped.
- freeze: position, dir, FSM, counters held; pending bits still latch; drawing continues.

## Test plan
- Reset, speedMag[0]=4, 10 frames → ropeX[0]: 100→104→108→112→116→116 (bounce), then 112; dir reverses exactly at MAX.
- dirToggle[2] pulse mid-frame, speed 2 from home 164 → next frame ropeX[2]=162.
- electroTrig[1], WARN/LIVE/COOL=60/120/30 → status 1 for 60 frames, 2 for 120, 3 for 30, then 0; second trig during LIVE ignored.
- Pixel (102,100) with rope 0 at x=100 OFF → ropeDR[0]=1, ropeRGB=8'hB4 one clk later; pixel (104,100) → 0; pixel (102,79) → 0.
- Rope 0 LIVE, monkeyDR=1 at (101,150) → shockHit=1, shockRope=0 two clks later; cleared at startOfFrame.
- freeze=1 for 5 frames during WARN → ropeX and counter unchanged; release resumes counting.
